// File: rtl/div_unit.sv
// div_unit: iterative 32-cycle restoring divider for MIPS DIV/DIVU, remainder on Hi, quotient on Lo
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             validIn,
    input  logic             sign,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             validOut,
    output logic             busy,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] r, q, b_abs, a_orig, r_n, q_n, a_in_abs, b_in_abs;
    logic [WIDTH:0] t;
    logic [CW-1:0] cnt;
    logic neg_q, neg_r, dz, ge, last;
    // One restoring step; the remainder stays below |B| so WIDTH bits hold it, T needs the extra bit
    always_comb begin
        a_in_abs = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
        b_in_abs = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;
        t = {r, q[WIDTH-1]};
        ge = t >= {1'b0, b_abs};
        r_n = ge ? t[WIDTH-1:0] - b_abs : t[WIDTH-1:0];
        q_n = {q[WIDTH-2:0], ge};
        last = cnt == CW'(WIDTH - 1);
        state_n = state == IDLE ? (validIn ? BUSY : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) : IDLE;
    end
    // State, operand capture, iteration and result registers; outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            validOut <= 1'b0;
            busy <= 1'b0;
            Hi <= '0;
            Lo <= '0;
            r <= '0;
            q <= '0;
            b_abs <= '0;
            a_orig <= '0;
            cnt <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
        end else begin
            state <= state_n;
            validOut <= state_n == DONE;
            busy <= state_n != IDLE;
            if (state == IDLE && validIn) begin
                a_orig <= SrcA;
                neg_q <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                neg_r <= sign & SrcA[WIDTH-1];
                b_abs <= b_in_abs;
                dz <= SrcB == '0;
                r <= '0;
                q <= a_in_abs;
                cnt <= '0;
            end
            if (state == BUSY) begin
                r <= r_n;
                q <= q_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    Lo <= dz ? '1 : (neg_q ? -q_n : q_n);
                    Hi <= dz ? a_orig : (neg_r ? -r_n : r_n);
                end
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: table-driven and randomized self-checking bench for div_unit
module tb_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        validIn = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic        validOut, busy;
    logic [31:0] Hi, Lo;

    int n_checks = 0;
    int n_fail = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .validIn(validIn), .sign(sign),
        .SrcA(SrcA), .SrcB(SrcB), .validOut(validOut), .busy(busy), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: MIPS semantics from 64-bit arithmetic (truncating divide, remainder signed like dividend)
    function automatic void model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
        longint sa, sb, qq, rr;
        if (b == 32'd0) begin
            lo = 32'hFFFFFFFF;
            hi = a;
            return;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        qq = sa / sb;
        rr = sa % sb;
        lo = qq[31:0];
        hi = rr[31:0];
    endfunction

    // Starts a division in cycle T; returns at the negedge of the validOut cycle with lat = cycles since T
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit hold,
                          output int lat);
        @(negedge clk);
        validIn = 1'b1;
        sign = s;
        SrcA = a;
        SrcB = b;
        @(negedge clk);
        lat = 1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        if (!hold) begin
            validIn = 1'b0;
            SrcA = $urandom;
            SrcB = $urandom;
            sign = ~s;
        end
        while (!validOut && lat < 80) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input string name);
        @(negedge clk);
        validIn = 1'b0;
        chk({name, "_pulse_end"}, {31'd0, validOut}, 32'd0);
        chk({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[8];
    int lat;
    logic [31:0] elo, ehi, lo1, hi1;
    logic rs;
    logic [31:0] ra, rb;

    initial begin
        vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
        vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
        vecs[3] = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1};
        vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
        vecs[6] = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678};
        vecs[7] = '{1'b1, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_validOut", {31'd0, validOut}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_Hi", Hi, 32'd0);
        chk("reset_Lo", Lo, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_div(vecs[i].s, vecs[i].a, vecs[i].b, 1'b1, lat);
            chk($sformatf("vec%0d_latency", i), lat, 32'd33);
            chk($sformatf("vec%0d_Lo", i), Lo, vecs[i].lo);
            chk($sformatf("vec%0d_Hi", i), Hi, vecs[i].hi);
            finish_op($sformatf("vec%0d", i));
        end

        // Reset in the middle of an operation: no pulse, outputs cleared
        do_div(1'b0, 32'd1000, 32'd3, 1'b0, lat);
        finish_op("pre_reset");
        @(negedge clk);
        validIn = 1'b1;
        sign = 1'b0;
        SrcA = 32'd999;
        SrcB = 32'd10;
        @(negedge clk);
        validIn = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_Hi", Hi, 32'd0);
        chk("abort_Lo", Lo, 32'd0);
        begin
            int pulses = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (validOut) pulses++;
            end
            chk("abort_no_pulse", pulses, 32'd0);
        end
        do_div(1'b0, 32'd999, 32'd10, 1'b0, lat);
        chk("after_abort_latency", lat, 32'd33);
        chk("after_abort_Lo", Lo, 32'd99);
        chk("after_abort_Hi", Hi, 32'd9);
        finish_op("after_abort");

        // Back-to-back with validIn held: first result stays until the second DONE
        do_div(1'b1, 32'hFFFFFF9C, 32'd7, 1'b1, lat);
        chk("b2b_first_latency", lat, 32'd33);
        lo1 = Lo;
        hi1 = Hi;
        chk("b2b_first_Lo", Lo, 32'hFFFFFFF2);
        chk("b2b_first_Hi", Hi, 32'hFFFFFFFE);
        SrcA = 32'd500;
        SrcB = 32'd9;
        sign = 1'b0;
        begin
            int gap = 0;
            int held_bad = 0;
            do begin
                if (Lo !== lo1 || Hi !== hi1) held_bad++;
                @(negedge clk);
                gap++;
            end while (!validOut && gap < 80);
            chk("b2b_gap", gap, 32'd34);
            chk("b2b_hold_first", held_bad, 32'd0);
        end
        chk("b2b_second_Lo", Lo, 32'd55);
        chk("b2b_second_Hi", Hi, 32'd5);
        finish_op("b2b");

        // Randomized operands against the reference, operands scrambled during BUSY half the time
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: begin ra = 32'h80000000; rb = $urandom; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            model(rs, ra, rb, elo, ehi);
            do_div(rs, ra, rb, 1'($urandom_range(0, 1)), lat);
            chk($sformatf("rnd%0d_latency", i), lat, 32'd33);
            chk($sformatf("rnd%0d_Lo s=%0d a=%08h b=%08h", i, rs, ra, rb), Lo, elo);
            chk($sformatf("rnd%0d_Hi s=%0d a=%08h b=%08h", i, rs, ra, rb), Hi, ehi);
            finish_op($sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
